fruit_spawner: RTL and testbench
================================

Name: fruit_spawner

Overview:
- Responder to the snake game logic's eat handshake: on each rising edge of `comer` it bumps the score, cycles the fruit colour and places a new fruit on the 10-px grid, never under the snake head.
- Drives `fruitPositionX/Y` and `Rfruta/Gfruta/Bfruta` back into the game logic.
- On the game logic's `reset` pulse (wall hit), it clears the score and respawns the fruit.

Parameters:
- SEED, 16'hACE1, LFSR seed; must be non-zero.
- MAX_TRIES, 8, rejected LFSR samples allowed before falling back to a fixed cell.
- SCORE_W, 14, score width; score saturates at 2^SCORE_W-1.
- INIT_COL, 30, fruit column after `rst`.
- INIT_ROW, 20, fruit row after `rst`.

Ports:
- uclk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- comer  in  1  eat flag from game logic; a level held for a whole move period.
- game_reset  in  1  game-over pulse/level from game logic.
- headX  in  12  snake head centre X.
- headY  in  12  snake head centre Y.
- fruitPositionX  out  12  fruit centre X; always 5+10*col, col 0..79.
- fruitPositionY  out  12  fruit centre Y; always 5+10*row, row 0..59.
- Rfruta  out  3  fruit red.
- Gfruta  out  3  fruit green.
- Bfruta  out  2  fruit blue.
- fruit_valid  out  1  high when the fruit position is settled (state ACTIVE).
- score  out  SCORE_W  fruits eaten since the last reset or game_reset.

Behaviour:
- Clock and reset: single clock `uclk`. Reset `rst` is synchronous and active-high.
- `rst` values:
  - fruit at INIT_COL/INIT_ROW, i.e. X=305, Y=205 with defaults;
  - score=0; colour index 0, so R=7, G=0, B=0;
  - fruit_valid=1; state ACTIVE; lfsr=SEED; comer_q=0; tries=0.
- LFSR:
  - 16-bit Fibonacci, x^16+x^14+x^13+x^11+1.
  - Advances every cycle except during `rst`.
- Edge detect: comer_q <= comer each cycle; eat = comer & ~comer_q.
- Colour palette, index 0..3 wrapping:
  - 0: red 7/0/0
  - 1: green 0/7/0
  - 2: orange 7/4/0
  - 3: magenta 7/0/3
  - Never produces white 7/7/3 or snake blue 0/0/3.
- FSM, states ACTIVE and SPAWN:
  - ACTIVE, eat=1: next cycle state=SPAWN, fruit_valid=0, score+1 (saturating), colour index+1, tries=0.
  - ACTIVE, game_reset=1: next cycle state=SPAWN, score=0, colour unchanged, tries=0.
  - SPAWN, per cycle: sample col=lfsr[6:0], row=lfsr[13:8].
    - Accept if col<80, row<60 and the candidate X/Y does not equal headX/headY.
    - On accept: next cycle outputs update atomically, state=ACTIVE, fruit_valid=1.
    - On reject: tries+1.
  - SPAWN, tries==MAX_TRIES: take fallback cell A (col 20, row 15 -> 205,155); if A equals the head, take B (col 60, row 45 -> 605,455). Return to ACTIVE next cycle.
  - Spawn latency: 1 to MAX_TRIES+1 cycles after entering SPAWN. Bounded, and far below a move period.
- Arithmetic: pixel = 5 + (c<<3) + (c<<1), zero-extended to 12 bits. No multipliers.
- Output hold: fruit position and colour outputs hold their old values throughout SPAWN.
- Priority and boundary conditions:
  - `rst` overrides everything.
  - game_reset and eat in the same cycle: game_reset wins; score=0 with no increment, colour unchanged.
  - eat or game_reset while in SPAWN: game_reset clears the score; eat is ignored (comer_q still tracks).
  - comer held high for many cycles: exactly one increment.
  - Score saturation: at 2^SCORE_W-1, further eats leave the score unchanged; colour still cycles.
  - `rst` mid-SPAWN: immediate return to reset values.

Decomposition:
- Shared package `snake_pkg` holds:
  - GRID=10, HALF=5, COLS=80, ROWS=60;
  - the palette constants;
  - the state enum {ACTIVE, SPAWN};
  - the fallback cells A and B.
- One sub-module, `lfsr16` (SEED parameter, enable input, 16-bit state output), reused later for other random features.

Test Plan:
- Reset: `rst` for 2 cycles -> X=305, Y=205, RGB=7/0/0, score=0, fruit_valid=1.
- Single eat: comer 0->1 and held 500 cycles -> score=1 (not 500), RGB=0/7/0, fruit_valid low for 1..9 cycles then high. New X in {5,15..795} and Y in {5,15..595}; new position != head.
- Fallback: MAX_TRIES=0 with SEED giving col>=80, head=(45,45) -> fruit=(205,155). Repeat with head=(205,155) -> fruit=(605,455).
- Simultaneous: score=3, game_reset and a comer rising edge in the same cycle -> score=0, colour unchanged, respawn completes.
- Saturation: SCORE_W=2, 5 eat edges -> score=3; colour index sequence 1,2,3,0,1.
- Random soak: 2000 eats with the head moved pseudo-randomly on the grid -> fruit always on grid, never equals head, fruit_valid recovers within MAX_TRIES+2 cycles.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake-game constants: grid geometry, fruit palette, spawner states and fallback cells.
package snake_pkg;

  localparam int unsigned GRID  = 10;
  localparam int unsigned HALF  = 5;
  localparam int unsigned COLS  = 80;
  localparam int unsigned ROWS  = 60;
  localparam int unsigned PIX_W = 12;
  localparam int unsigned COL_W = 7;
  localparam int unsigned ROW_W = 6;

  typedef enum logic {
    ACTIVE = 1'b0,
    SPAWN  = 1'b1
  } spawn_state_e;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb_t;

  // White and snake blue are deliberately absent so the fruit never blends in.
  localparam rgb_t PAL_RED     = '{r: 3'd7, g: 3'd0, b: 2'd0};
  localparam rgb_t PAL_GREEN   = '{r: 3'd0, g: 3'd7, b: 2'd0};
  localparam rgb_t PAL_ORANGE  = '{r: 3'd7, g: 3'd4, b: 2'd0};
  localparam rgb_t PAL_MAGENTA = '{r: 3'd7, g: 3'd0, b: 2'd3};

  localparam logic [COL_W-1:0] FB_A_COL = 7'd20;
  localparam logic [COL_W-1:0] FB_A_ROW = 7'd15;
  localparam logic [COL_W-1:0] FB_B_COL = 7'd60;
  localparam logic [COL_W-1:0] FB_B_ROW = 7'd45;

  // Cell index to pixel centre: 5 + 10*c using shifts only.
  function automatic logic [PIX_W-1:0] cell_to_pix(input logic [COL_W-1:0] c);
    return PIX_W'(HALF) + (PIX_W'(c) << 3) + (PIX_W'(c) << 1);
  endfunction

  function automatic rgb_t palette(input logic [1:0] idx);
    case (idx)
      2'd0:    return PAL_RED;
      2'd1:    return PAL_GREEN;
      2'd2:    return PAL_ORANGE;
      default: return PAL_MAGENTA;
    endcase
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic        fb;

  assign fb = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SEED;
    end else if (en_i) begin
      state_q <= {state_q[14:0], fb};
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/fruit_spawner.sv
// Fruit placement for the snake game: scores eats, cycles the colour and respawns
// the fruit on the grid, never under the snake head.
module fruit_spawner
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned MAX_TRIES = 8,
  parameter int unsigned SCORE_W   = 14,
  parameter int unsigned INIT_COL  = 30,
  parameter int unsigned INIT_ROW  = 20
) (
  input  logic               uclk,
  input  logic               rst,
  input  logic               comer,
  input  logic               game_reset,
  input  logic [11:0]        headX,
  input  logic [11:0]        headY,
  output logic [11:0]        fruitPositionX,
  output logic [11:0]        fruitPositionY,
  output logic [2:0]         Rfruta,
  output logic [2:0]         Gfruta,
  output logic [1:0]         Bfruta,
  output logic               fruit_valid,
  output logic [SCORE_W-1:0] score
);

  localparam int unsigned        TRY_W     = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [PIX_W-1:0]   INIT_X    = cell_to_pix(COL_W'(INIT_COL));
  localparam logic [PIX_W-1:0]   INIT_Y    = cell_to_pix(COL_W'(INIT_ROW));
  localparam logic [PIX_W-1:0]   FB_A_X    = cell_to_pix(FB_A_COL);
  localparam logic [PIX_W-1:0]   FB_A_Y    = cell_to_pix(FB_A_ROW);
  localparam logic [PIX_W-1:0]   FB_B_X    = cell_to_pix(FB_B_COL);
  localparam logic [PIX_W-1:0]   FB_B_Y    = cell_to_pix(FB_B_ROW);

  if (SEED == 16'd0 || GRID != 10) begin : g_bad_cfg
    $error("fruit_spawner: SEED must be non-zero and GRID must be 10");
  end

  spawn_state_e       state_q, state_d;
  logic               comer_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [1:0]         cidx_q, cidx_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [PIX_W-1:0]   fx_q, fx_d, fy_q, fy_d;
  rgb_t               rgb_q, rgb_d;
  logic               valid_q, valid_d;

  logic [15:0]        lfsr;
  logic               unused_lfsr;
  logic               eat;
  logic [COL_W-1:0]   cand_col;
  logic [ROW_W-1:0]   cand_row;
  logic [PIX_W-1:0]   cand_x, cand_y;
  logic               cand_ok;
  logic               head_on_a;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk_i   (uclk),
    .rst_i   (rst),
    .en_i    (1'b1),
    .state_o (lfsr)
  );

  assign unused_lfsr = ^{lfsr[15:14], lfsr[7]};
  assign eat         = comer & ~comer_q;
  assign cand_col    = lfsr[6:0];
  assign cand_row    = lfsr[13:8];
  assign cand_x      = cell_to_pix(cand_col);
  assign cand_y      = cell_to_pix(COL_W'(cand_row));
  assign cand_ok     = (cand_col < COL_W'(COLS)) && (cand_row < ROW_W'(ROWS)) &&
                       !((cand_x == headX) && (cand_y == headY));
  assign head_on_a   = (headX == FB_A_X) && (headY == FB_A_Y);

  // Next-state: eat/game_reset start a spawn, SPAWN samples one LFSR cell per cycle.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    cidx_d  = cidx_q;
    tries_d = tries_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    rgb_d   = rgb_q;
    valid_d = valid_q;
    unique case (state_q)
      ACTIVE: begin
        if (game_reset) begin
          state_d = SPAWN;
          score_d = '0;
          tries_d = '0;
          valid_d = 1'b0;
        end else if (eat) begin
          state_d = SPAWN;
          score_d = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);
          cidx_d  = cidx_q + 2'd1;
          tries_d = '0;
          valid_d = 1'b0;
        end
      end
      SPAWN: begin
        if (game_reset) begin
          score_d = '0;
        end
        if (cand_ok) begin
          state_d = ACTIVE;
          fx_d    = cand_x;
          fy_d    = cand_y;
          rgb_d   = palette(cidx_q);
          valid_d = 1'b1;
        end else if (tries_q == TRY_W'(MAX_TRIES)) begin
          state_d = ACTIVE;
          fx_d    = head_on_a ? FB_B_X : FB_A_X;
          fy_d    = head_on_a ? FB_B_Y : FB_A_Y;
          rgb_d   = palette(cidx_q);
          valid_d = 1'b1;
        end else begin
          tries_d = tries_q + TRY_W'(1);
        end
      end
      default: state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge uclk) begin
    if (rst) begin
      state_q <= ACTIVE;
      comer_q <= 1'b0;
      score_q <= '0;
      cidx_q  <= '0;
      tries_q <= '0;
      fx_q    <= INIT_X;
      fy_q    <= INIT_Y;
      rgb_q   <= PAL_RED;
      valid_q <= 1'b1;
    end else begin
      state_q <= state_d;
      comer_q <= comer;
      score_q <= score_d;
      cidx_q  <= cidx_d;
      tries_q <= tries_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      rgb_q   <= rgb_d;
      valid_q <= valid_d;
    end
  end

  assign fruitPositionX = fx_q;
  assign fruitPositionY = fy_q;
  assign Rfruta         = rgb_q.r;
  assign Gfruta         = rgb_q.g;
  assign Bfruta         = rgb_q.b;
  assign fruit_valid    = valid_q;
  assign score          = score_q;

endmodule

// File: tb/tb_fruit_spawner.sv
// Randomized bench for fruit_spawner: default instance plus a MAX_TRIES=0 / SCORE_W=2 instance.
module tb_fruit_spawner;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        uclk = 1'b0;
  logic        rst, comer, game_reset;
  logic [11:0] headX, headY;
  logic [11:0] x0, y0, x1, y1;
  logic [2:0]  r0, g0, r1, g1;
  logic [1:0]  b0, b1;
  logic        v0, v1;
  logic [13:0] s0;
  logic [1:0]  s1;

  int n_checks = 0;
  int n_fail   = 0;
  int es0, es1, cidx;
  logic [15:0] m_lfsr;

  always #5 uclk = ~uclk;

  fruit_spawner #(.SEED(SEED)) u_dut (
    .uclk(uclk), .rst(rst), .comer(comer), .game_reset(game_reset),
    .headX(headX), .headY(headY),
    .fruitPositionX(x0), .fruitPositionY(y0),
    .Rfruta(r0), .Gfruta(g0), .Bfruta(b0),
    .fruit_valid(v0), .score(s0)
  );

  fruit_spawner #(.SEED(SEED), .MAX_TRIES(0), .SCORE_W(2)) u_alt (
    .uclk(uclk), .rst(rst), .comer(comer), .game_reset(game_reset),
    .headX(headX), .headY(headY),
    .fruitPositionX(x1), .fruitPositionY(y1),
    .Rfruta(r1), .Gfruta(g1), .Bfruta(b1),
    .fruit_valid(v1), .score(s1)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Reference LFSR value held between clock edges.
  always @(posedge uclk) m_lfsr <= rst ? SEED : lfsr_step(m_lfsr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pal(input int i);
    case (i)
      0:       return {3'd7, 3'd0, 2'd0};
      1:       return {3'd0, 3'd7, 2'd0};
      2:       return {3'd7, 3'd4, 2'd0};
      default: return {3'd7, 3'd0, 2'd3};
    endcase
  endfunction

  function automatic bit in_range(input logic [15:0] s);
    return (int'(s[6:0]) < 80) && (int'(s[13:8]) < 60);
  endfunction

  // First acceptable LFSR cell after spawn entry, else the fallback cell; nlow = cycles not valid.
  function automatic void predict(input logic [15:0] l0, input int hx, input int hy,
                                  input int max_tries, output int px, output int py,
                                  output int nlow);
    logic [15:0] s;
    int c, r;
    s = l0;
    for (int i = 0; i <= max_tries; i++) begin
      s = lfsr_step(s);
      c = int'(s[6:0]);
      r = int'(s[13:8]);
      if (c < 80 && r < 60 && !((5 + 10 * c) == hx && (5 + 10 * r) == hy)) begin
        px = 5 + 10 * c;
        py = 5 + 10 * r;
        nlow = i + 1;
        return;
      end
    end
    nlow = max_tries + 1;
    if (hx == 205 && hy == 155) begin
      px = 605; py = 455;
    end else begin
      px = 205; py = 155;
    end
  endfunction

  task automatic check_reset_values();
    check("rst_x0", 32'(x0), 305);  check("rst_y0", 32'(y0), 205);
    check("rst_rgb0", 32'({r0, g0, b0}), 32'(pal(0)));
    check("rst_score0", 32'(s0), 0); check("rst_valid0", 32'(v0), 1);
    check("rst_x1", 32'(x1), 305);  check("rst_y1", 32'(y1), 205);
    check("rst_rgb1", 32'({r1, g1, b1}), 32'(pal(0)));
    check("rst_score1", 32'(s1), 0); check("rst_valid1", 32'(v1), 1);
  endtask

  // Drive one eat and/or game_reset from ACTIVE and check the resulting spawn on both instances.
  task automatic do_event(input bit eat, input bit grst, input int hold);
    int ex0, ey0, en0, ex1, ey1, en1, lo0, lo1;
    logic [11:0] ox0, oy0, ox1, oy1;
    bit d0, d1;
    predict(m_lfsr, int'(headX), int'(headY), 8, ex0, ey0, en0);
    predict(m_lfsr, int'(headX), int'(headY), 0, ex1, ey1, en1);
    if (grst) begin
      es0 = 0; es1 = 0;
    end else if (eat) begin
      es0 = (es0 == 16383) ? es0 : es0 + 1;
      es1 = (es1 == 3) ? es1 : es1 + 1;
      cidx = (cidx + 1) % 4;
    end
    ox0 = x0; oy0 = y0; ox1 = x1; oy1 = y1;
    comer = eat; game_reset = grst;
    lo0 = 0; lo1 = 0; d0 = 0; d1 = 0;
    for (int c = 0; c < 20 && !(d0 && d1); c++) begin
      @(negedge uclk);
      game_reset = 1'b0;
      if (!d0) begin
        if (v0) d0 = 1;
        else begin lo0++; check("hold_x0", 32'(x0), 32'(ox0)); check("hold_y0", 32'(y0), 32'(oy0)); end
      end
      if (!d1) begin
        if (v1) d1 = 1;
        else begin lo1++; check("hold_x1", 32'(x1), 32'(ox1)); check("hold_y1", 32'(y1), 32'(oy1)); end
      end
    end
    check("spawn_done", 32'(d0 && d1), 1);
    check("lat0", lo0, en0);          check("lat1", lo1, en1);
    check("x0", 32'(x0), ex0);        check("y0", 32'(y0), ey0);
    check("x1", 32'(x1), ex1);        check("y1", 32'(y1), ey1);
    check("nothead0", 32'(x0 == headX && y0 == headY), 0);
    check("rgb0", 32'({r0, g0, b0}), 32'(pal(cidx)));
    check("rgb1", 32'({r1, g1, b1}), 32'(pal(cidx)));
    check("score0", 32'(s0), es0);    check("score1", 32'(s1), es1);
    if (hold > 0) begin
      repeat (hold) @(negedge uclk);
      check("held_score0", 32'(s0), es0);
      check("held_score1", 32'(s1), es1);
    end
    comer = 1'b0;
    @(negedge uclk);
  endtask

  task automatic wait_reject();
    for (int i = 0; i < 200 && in_range(lfsr_step(m_lfsr)); i++) @(negedge uclk);
    check("fb_wait", 32'(in_range(lfsr_step(m_lfsr))), 0);
  endtask

  initial begin
    int col, row;
    logic [15:0] nxt;
    rst = 1'b1; comer = 1'b0; game_reset = 1'b0; headX = 12'd45; headY = 12'd45;
    es0 = 0; es1 = 0; cidx = 0;
    repeat (2) @(negedge uclk);
    check_reset_values();
    rst = 1'b0;
    @(negedge uclk);

    // Single eat held 500 cycles, then up to score 3.
    do_event(1'b1, 1'b0, 500);
    do_event(1'b1, 1'b0, 2);
    do_event(1'b1, 1'b0, 0);

    // game_reset and a comer edge together: reset wins, colour unchanged.
    do_event(1'b1, 1'b1, 2);

    // rst during a spawn returns straight to reset values.
    comer = 1'b1;
    @(negedge uclk);
    rst = 1'b1; comer = 1'b0;
    @(negedge uclk);
    check_reset_values();
    rst = 1'b0; es0 = 0; es1 = 0; cidx = 0;
    @(negedge uclk);

    // Five eats: SCORE_W=2 instance saturates at 3, colour 1,2,3,0,1.
    for (int i = 0; i < 5; i++) do_event(1'b1, 1'b0, 1);
    check("sat_score1", 32'(s1), 3);
    check("sat_rgb", 32'({r0, g0, b0}), 32'(pal(1)));

    // Fallback cells on the MAX_TRIES=0 instance.
    headX = 12'd45; headY = 12'd45;
    wait_reject();
    do_event(1'b1, 1'b0, 0);
    check("fbA_x", 32'(x1), 205); check("fbA_y", 32'(y1), 155);
    headX = 12'd205; headY = 12'd155;
    wait_reject();
    do_event(1'b1, 1'b0, 0);
    check("fbB_x", 32'(x1), 605); check("fbB_y", 32'(y1), 455);

    // Soak: random head, sometimes parked on the next candidate cell.
    for (int i = 0; i < 2000; i++) begin
      col = int'($urandom_range(0, 79));
      row = int'($urandom_range(0, 59));
      nxt = lfsr_step(m_lfsr);
      if ($urandom_range(0, 3) == 0 && in_range(nxt)) begin
        col = int'(nxt[6:0]);
        row = int'(nxt[13:8]);
      end
      headX = 12'(5 + 10 * col);
      headY = 12'(5 + 10 * row);
      if ($urandom_range(0, 15) == 0) do_event(1'b0, 1'b1, 0);
      else do_event(1'b1, 1'b0, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
